// File: rtl/modiff_pkg.sv
// Shared constants, FSM state type and width helpers for the modiff stream engine.
package modiff_pkg;

  localparam int MODE_AMDF = 0;
  localparam int MODE_SQR  = 1;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_COMPUTE,
    ST_REPORT
  } state_t;

  // W terms of the per-sample metric never exceed this width, so the sum cannot overflow.
  function automatic int acc_width(input int data_width, input int mode, input int window_bits);
    return data_width * (mode + 1) + window_bits;
  endfunction

  function automatic int tau_width(input int max_tau);
    return $clog2(max_tau + 1);
  endfunction

endpackage

// File: rtl/modiff_diff_acc.sv
// Difference/metric stage followed by the accumulator; sum is the running total including the
// metric currently waiting to be added, so the final value is visible one cycle before acc holds it.
module modiff_diff_acc
  import modiff_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MODE       = MODE_AMDF,
  parameter int ACC_WIDTH  = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0]  sum
);

  localparam int MW = DATA_WIDTH * (MODE + 1);

  logic signed [DATA_WIDTH:0]     diff;
  logic signed [2*DATA_WIDTH+1:0] sq;
  logic        [DATA_WIDTH:0]     mag;
  logic        [MW-1:0]           metric_c;
  logic        [MW-1:0]           metric_q;
  logic                           metric_v;
  logic        [ACC_WIDTH-1:0]    acc;

  // NOTE: every variable is assigned on every pass through this block, so no latch can form.
  always_comb begin
    diff     = $signed({1'b0, a}) - $signed({1'b0, b});
    sq       = diff * diff;
    mag      = diff[DATA_WIDTH] ? $unsigned(-diff) : $unsigned(diff);
    metric_c = (MODE == MODE_SQR) ? MW'(sq) : MW'(mag);
  end

  assign sum = acc + (metric_v ? ACC_WIDTH'(metric_q) : '0);

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      metric_v <= 1'b0;
      metric_q <= '0;
      acc      <= '0;
    end else begin
      metric_v <= in_valid;
      metric_q <= metric_c;
      acc      <= clear ? '0 : sum;
    end
  end

endmodule

// File: rtl/modiff_stream_engine.sv
// Streaming difference-function engine: fills a circular buffer, sweeps tau over one window per
// frame, streams every d(tau), reports the argmin, then hops the frame base forward.
module modiff_stream_engine
  import modiff_pkg::*;
#(
  parameter int DATA_WIDTH       = 8,
  parameter int WINDOW_SIZE_BITS = 6,
  parameter int MIN_TAU          = 2,
  parameter int MAX_TAU          = 40,
  parameter int BUF_BITS         = 7,
  parameter int HOP              = 32,
  parameter int MODE             = MODE_AMDF,
  parameter int ACC_WIDTH        = acc_width(DATA_WIDTH, MODE, WINDOW_SIZE_BITS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [DATA_WIDTH-1:0]            s_data,
  output logic                             d_valid,
  output logic [tau_width(MAX_TAU)-1:0]    d_tau,
  output logic [ACC_WIDTH-1:0]             d_value,
  output logic                             r_valid,
  input  logic                             r_ready,
  output logic [tau_width(MAX_TAU)-1:0]    r_tau,
  output logic [ACC_WIDTH-1:0]             r_min,
  output logic                             busy
);

  localparam int W     = 1 << WINDOW_SIZE_BITS;
  localparam int DEPTH = 1 << BUF_BITS;
  localparam int TW    = tau_width(MAX_TAU);
  localparam int PW    = WINDOW_SIZE_BITS + 2;
  localparam int CW    = BUF_BITS + 1;

  localparam logic [PW-1:0] PH_ISSUE  = PW'(W);
  localparam logic [PW-1:0] PH_SUM    = PW'(W + 1);
  localparam logic [PW-1:0] PH_LAST   = PW'(W + 2);
  localparam logic [CW-1:0] FILL_NEED = CW'(W + MAX_TAU);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] HOP_C     = CW'(HOP);
  localparam logic [TW-1:0] TAU_FIRST = TW'(MIN_TAU);
  localparam logic [TW-1:0] TAU_LAST  = TW'(MAX_TAU);

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [BUF_BITS-1:0]   base, addr_a, addr_b;
  logic [CW-1:0]         count;
  logic [TW-1:0]         tau, best_tau;
  logic [PW-1:0]         ph;
  logic [DATA_WIDTH-1:0] rd_a, rd_b;
  logic                  rd_v, issue, take, tau_done;
  logic [ACC_WIDTH-1:0]  sum, best;

  assign s_ready  = !reset && (state == ST_FILL) && (count < DEPTH_C);
  assign take     = s_valid && s_ready;
  assign busy     = (state != ST_FILL);
  assign issue    = (state == ST_COMPUTE) && (ph < PH_ISSUE);
  assign tau_done = (state == ST_COMPUTE) && (ph == PH_SUM);
  assign addr_a   = base + BUF_BITS'(ph);
  assign addr_b   = addr_a + BUF_BITS'(tau);

  // NOTE: the sample buffer has no reset; every entry is written before a frame can read it.
  always_ff @(posedge clk) begin
    if (take) mem[base + count[BUF_BITS-1:0]] <= s_data;
    rd_a <= mem[addr_a];
    rd_b <= mem[addr_b];
  end

  modiff_diff_acc #(
    .DATA_WIDTH(DATA_WIDTH),
    .MODE      (MODE),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_diff_acc (
    .clk     (clk),
    .reset   (reset),
    .clear   (tau_done),
    .in_valid(rd_v),
    .a       (rd_a),
    .b       (rd_b),
    .sum     (sum)
  );

  // Per tau: phases 0..W-1 issue reads, W+1 captures the finished sum, W+2 carries the d_valid pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_FILL;
      count    <= '0;
      base     <= '0;
      tau      <= TAU_FIRST;
      ph       <= '0;
      rd_v     <= 1'b0;
      best     <= '0;
      best_tau <= '0;
      d_valid  <= 1'b0;
      d_tau    <= '0;
      d_value  <= '0;
      r_valid  <= 1'b0;
      r_tau    <= '0;
      r_min    <= '0;
    end else begin
      rd_v    <= issue;
      d_valid <= 1'b0;
      unique case (state)
        ST_FILL: begin
          if (take) count <= count + 1'b1;
          tau <= TAU_FIRST;
          ph  <= '0;
          if (count >= FILL_NEED) state <= ST_COMPUTE;
        end
        ST_COMPUTE: begin
          ph <= ph + 1'b1;
          if (tau_done) begin
            d_valid <= 1'b1;
            d_tau   <= tau;
            d_value <= sum;
            if (tau == TAU_FIRST || sum < best) begin
              best     <= sum;
              best_tau <= tau;
            end
          end
          if (ph == PH_LAST) begin
            ph <= '0;
            if (tau == TAU_LAST) begin
              state   <= ST_REPORT;
              r_valid <= 1'b1;
              r_tau   <= best_tau;
              r_min   <= best;
            end else begin
              tau <= tau + 1'b1;
            end
          end
        end
        ST_REPORT: begin
          if (r_valid && r_ready) begin
            r_valid <= 1'b0;
            base    <= base + BUF_BITS'(HOP);
            count   <= count - HOP_C;
            state   <= ST_FILL;
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_modiff_stream_engine.sv
// Directed bench: an AMDF and a squared-difference engine share one input stream and are
// compared against a reference difference function computed over the same sample array.
module tb_modiff_stream_engine;

  localparam int W = 64, MIN_TAU = 2, MAX_TAU = 40, HOP = 32, NTAU = 39, SPAN = 67;

  logic        clk = 1'b0;
  logic        reset, s_valid, r_ready;
  logic [7:0]  s_data;
  logic        s_ready, d_valid, r_valid, busy;
  logic [5:0]  d_tau, r_tau;
  logic [13:0] d_value, r_min;
  logic        q_s_ready, q_d_valid, q_r_valid, q_busy;
  logic [5:0]  q_d_tau, q_r_tau;
  logic [21:0] q_d_value, q_r_min;

  always #5 clk = ~clk;

  modiff_stream_engine dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .d_valid(d_valid), .d_tau(d_tau), .d_value(d_value),
    .r_valid(r_valid), .r_ready(r_ready), .r_tau(r_tau), .r_min(r_min), .busy(busy)
  );

  modiff_stream_engine #(.MODE(1)) dut_sqr (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(q_s_ready), .s_data(s_data),
    .d_valid(q_d_valid), .d_tau(q_d_tau), .d_value(q_d_value),
    .r_valid(q_r_valid), .r_ready(r_ready), .r_tau(q_r_tau), .r_min(q_r_min), .busy(q_busy)
  );

  int src [0:1023];
  int src_idx, src_limit, cyc;
  bit hs, busy_q;
  int dv_count, first_rel, last_pulse, gap_bad, order_bad, start_cyc, rv_cyc;
  int got_a [0:63];
  int got_q [0:63];
  int n_checks, n_pass;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic drive_inputs();
    s_valid = (src_idx < src_limit);
    s_data  = 8'(src[src_idx]);
  endtask

  task automatic clear_monitor();
    dv_count = 0; gap_bad = 0; order_bad = 0; rv_cyc = -1; first_rel = -1;
    for (int i = 0; i < 64; i++) begin
      got_a[i] = -1;
      got_q[i] = -1;
    end
  endtask

  // One clock: handshake sampled at the rising edge, outputs observed at the falling edge.
  task automatic tick();
    @(posedge clk);
    hs = s_valid && s_ready;
    @(negedge clk);
    cyc++;
    if (hs) src_idx++;
    if (busy && !busy_q) start_cyc = cyc;
    busy_q = busy;
    if (d_valid) begin
      if (dv_count == 0) first_rel = cyc - start_cyc + 1;
      else if (cyc - last_pulse != SPAN) gap_bad++;
      if (int'(d_tau) != MIN_TAU + dv_count) order_bad++;
      got_a[d_tau] = int'(d_value);
      last_pulse = cyc;
      dv_count++;
    end
    if (q_d_valid) got_q[q_d_tau] = int'(q_d_value);
    if (r_valid && rv_cyc < 0) rv_cyc = cyc;
    drive_inputs();
  endtask

  // kind: 0 sawtooth, 1 constant 128, 2 alternating 0/255, 3 100 Hz sine at 2 kHz, 4 scrambled ramp
  task automatic load(input int kind, input int limit);
    for (int i = 0; i < 1024; i++) begin
      case (kind)
        0: src[i] = (i % 20) * 10;
        1: src[i] = 128;
        2: src[i] = (i % 2 == 1) ? 255 : 0;
        3: src[i] = $rtoi(127.5 + 127.0 * $sin(2.0 * 3.14159265358979 * (i % 20) / 20.0));
        default: src[i] = (i * 37) % 256;
      endcase
    end
    src_idx = 0;
    src_limit = limit;
    drive_inputs();
  endtask

  function automatic int model_d(input int base, input int tau, input bit sqr);
    int s = 0;
    for (int n = 0; n < W; n++) begin
      int d = src[base + n] - src[base + n + tau];
      s += sqr ? d * d : (d < 0 ? -d : d);
    end
    return s;
  endfunction

  task automatic model_best(input int base, input bit sqr, output int bt, output int bv);
    bt = MIN_TAU;
    bv = model_d(base, MIN_TAU, sqr);
    for (int t = MIN_TAU + 1; t <= MAX_TAU; t++)
      if (model_d(base, t, sqr) < bv) begin
        bv = model_d(base, t, sqr);
        bt = t;
      end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    r_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    clear_monitor();
  endtask

  // Waits for the frame result and checks pulses, timing and every d value against the model.
  task automatic run_frame(input string name, input int base);
    int t = 0, bad_a = 0, bad_q = 0, bt, bv;
    while (!r_valid && t < 6000) begin
      tick();
      t++;
    end
    if (!r_valid) begin
      check({name, " timeout"}, 0, 1);
      return;
    end
    for (int tau = MIN_TAU; tau <= MAX_TAU; tau++) begin
      if (got_a[tau] != model_d(base, tau, 1'b0)) bad_a++;
      if (got_q[tau] != model_d(base, tau, 1'b1)) bad_q++;
    end
    check({name, " pulses"}, dv_count, NTAU);
    check({name, " first_pulse"}, first_rel, SPAN);
    check({name, " gap_bad"}, gap_bad, 0);
    check({name, " tau_order_bad"}, order_bad, 0);
    check({name, " r_valid_lag"}, rv_cyc - last_pulse, 1);
    check({name, " d_amdf_bad"}, bad_a, 0);
    check({name, " d_sqr_bad"}, bad_q, 0);
    check({name, " sqr_r_valid"}, q_r_valid, 1);
    model_best(base, 1'b0, bt, bv);
    check({name, " r_tau"}, r_tau, bt);
    check({name, " r_min"}, r_min, bv);
    model_best(base, 1'b1, bt, bv);
    check({name, " sqr_r_tau"}, q_r_tau, bt);
    check({name, " sqr_r_min"}, q_r_min, bv);
  endtask

  task automatic ack();
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    check("ack r_valid_low", r_valid, 0);
    clear_monitor();
  endtask

  initial begin
    int hold_bad, t;
    logic [5:0]  snap_tau;
    logic [13:0] snap_min;
    n_checks = 0; n_pass = 0; cyc = 0; busy_q = 0;
    reset = 1'b1; r_ready = 1'b0;
    load(0, 0);
    #1;
    check("reset s_ready", s_ready, 0);
    do_reset();
    check("reset flags", {d_valid, r_valid, busy, s_ready}, 4'b0001);
    check("reset d_out", {d_tau, d_value}, 0);
    check("reset r_out", {r_tau, r_min}, 0);

    // Sawtooth, period 20
    load(0, 104);
    run_frame("saw", 0);
    check("saw d20", got_a[20], 0);
    check("saw d2", got_a[2], 2240);
    check("saw r_tau20", r_tau, 20);
    ack();

    // Constant input: all zero, tie keeps smallest tau
    do_reset();
    load(1, 104);
    run_frame("const", 0);
    check("const d17", got_a[17], 0);
    check("const r_tau", r_tau, MIN_TAU);
    ack();

    // Alternating 0/255
    do_reset();
    load(2, 104);
    run_frame("alt", 0);
    check("alt sqr d3", got_q[3], 4161600);
    check("alt sqr d4", got_q[4], 0);
    check("alt amdf d3", got_a[3], 16320);
    check("alt sqr r_tau", q_r_tau, 2);
    ack();

    // Backpressured report, then a hop that needs exactly HOP fresh samples
    do_reset();
    load(0, 104);
    run_frame("hold", 0);
    snap_tau = r_tau;
    snap_min = r_min;
    hold_bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (!r_valid || r_tau !== snap_tau || r_min !== snap_min || s_ready || !busy) hold_bad++;
    end
    check("hold stable_bad", hold_bad, 0);
    ack();
    src_limit = 104 + HOP - 1;
    for (int i = 0; i < 60; i++) tick();
    check("hop short busy", busy, 0);
    check("hop short accepted", src_idx, 104 + HOP - 1);
    src_limit = 104 + HOP;
    run_frame("hop", HOP);
    check("hop r_tau20", r_tau, 20);
    ack();

    // Continuous sine: successive frames, buffer wraps
    do_reset();
    load(3, 300);
    for (int k = 0; k < 7; k++) begin
      run_frame($sformatf("sine%0d", k), k * HOP);
      check($sformatf("sine%0d r_tau20", k), r_tau, 20);
      ack();
    end

    // Reset in the middle of tau=10, then a fresh frame
    do_reset();
    load(0, 104);
    t = 0;
    do begin
      tick();
      t++;
    end while (!(d_valid && d_tau == 6'd9) && t < 3000);
    check("midreset reached_tau9", d_tau, 9);
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    load(4, 104);
    tick();
    reset = 1'b0;
    #1;
    check("midreset flags", {d_valid, r_valid, busy, s_ready}, 4'b0001);
    check("midreset d_out", {d_tau, d_value}, 0);
    check("midreset r_out", {r_tau, r_min}, 0);
    clear_monitor();
    run_frame("refill", 0);
    ack();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/modiff_stream_engine.md
Name: modiff_stream_engine

Overview:
Streaming successor to modiff_module. Accepts samples one at a time over a valid/ready handshake into an internal circular buffer. For each analysis frame it computes the difference function d(tau) = sum over n=0..W-1 of f(x[b+n] - x[b+n+tau]) for every tau in [MIN_TAU, MAX_TAU], streams each d(tau) out, and reports the minimising tau. Frames advance by a programmable hop. Two selectable metrics: AMDF (absolute difference) or squared difference. Sits between the audio sample source and the pitch decision logic.

Parameters:
DATA_WIDTH, 8, unsigned sample width
WINDOW_SIZE_BITS, 6, log2 of window length W (W = 64)
MIN_TAU, 2, smallest lag evaluated (>= 1)
MAX_TAU, 40, largest lag evaluated (> MIN_TAU)
BUF_BITS, 7, log2 of buffer depth; 2^BUF_BITS >= W + MAX_TAU
HOP, 32, samples discarded between frames (1 <= HOP <= W)
MODE, 0, 0 = AMDF |a-b|, 1 = squared (a-b)^2
ACC_WIDTH, DATA_WIDTH*(MODE+1)+WINDOW_SIZE_BITS, accumulator / result width (derived)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
s_valid  in  1  input sample valid
s_ready  out  1  engine can accept a sample
s_data  in  DATA_WIDTH  unsigned sample
d_valid  out  1  one-cycle pulse: d_tau/d_value are valid (no backpressure)
d_tau  out  $clog2(MAX_TAU+1)  lag of current d_value
d_value  out  ACC_WIDTH  d(d_tau) for current frame
r_valid  out  1  frame result valid; held until r_ready
r_ready  in  1  consumer accepts frame result
r_tau  out  $clog2(MAX_TAU+1)  argmin tau of frame
r_min  out  ACC_WIDTH  d(r_tau)
busy  out  1  high in COMPUTE or REPORT

Behaviour:
- Reset values: s_ready=0 in reset cycle, then 1; d_valid=0, r_valid=0, busy=0, d_tau/d_value/r_tau/r_min=0. Sample count=0, base pointer=0, state=FILL. Buffer RAM contents are not cleared.
- A sample is accepted when s_valid && s_ready at a rising edge. It is written at (base+count) mod 2^BUF_BITS, and count increments.
- s_ready = (state==FILL) && (count < 2^BUF_BITS).
- State FILL: when count >= W+MAX_TAU at a clock edge, go to COMPUTE on the next cycle. A sample accepted in that same cycle still counts.
- State COMPUTE: for tau = MIN_TAU..MAX_TAU, in ascending order.
  - Issue cycles: W cycles, one pair read per cycle, n = 0..W-1.
  - Pipeline: read (register array, two read ports) -> diff/metric -> accumulate.
  - Drain: 3 cycles. Each tau therefore occupies exactly W+3 cycles; taus do not overlap.
  - Timing: d_valid pulses on the last drain cycle of each tau. The first pulse comes W+3 cycles after COMPUTE entry, then one every W+3 cycles.
  - Total pulses per frame: MAX_TAU-MIN_TAU+1.
- Arithmetic:
  - Difference is computed at DATA_WIDTH+1 bits, signed.
  - MODE 0: magnitude. MODE 1: product, 2*DATA_WIDTH bits.
  - Accumulator is ACC_WIDTH and cannot overflow by construction.
  - Addresses wrap modulo 2^BUF_BITS.
- Minimum tracking: best is initialised from the first tau. It is replaced only on strict less-than, so ties keep the smaller tau.
- After the last tau's d_valid, go to REPORT next cycle with r_valid=1. r_tau and r_min stay stable while r_valid && !r_ready.
- REPORT: on r_valid && r_ready, in the next cycle:
  - r_valid=0;
  - base += HOP (mod), count -= HOP;
  - state = FILL. FILL re-enters COMPUTE immediately if count is still sufficient.
- Input is stalled (s_ready=0) throughout COMPUTE and REPORT.
- Reset asserted in any state aborts the frame in that cycle and restores all reset values. No partial d_valid or r_valid appears afterwards.

Decomposition:
- Package modiff_pkg:
  - MODE_AMDF=0 and MODE_SQR=1 constants;
  - state enum (FILL, COMPUTE, REPORT);
  - ACC_WIDTH and tau-width functions.
- One natural sub-module: modiff_diff_acc. It holds the diff/metric/accumulate pipeline with clear and valid-in, parameterised by DATA_WIDTH, MODE and ACC_WIDTH.
- Buffer, pointers and FSM stay in the top level.

Test Plan:
- Sawtooth x[i] = (i mod 20)*10, MODE 0, defaults:
  - d(20)=0, d(2) = 64*|...| per golden model;
  - r_tau=20, r_min=0;
  - 39 d_valid pulses spaced 67 cycles apart.
- Constant x=128:
  - every d_value=0;
  - r_tau=MIN_TAU=2 (tie rule);
  - first d_valid 67 cycles after COMPUTE entry.
- MODE 1, alternating 0/255:
  - even tau d=0, odd tau d = 64*65025 = 4161600 (no overflow in ACC_WIDTH=22);
  - r_tau=2.
- Hold r_ready=0 for 50 cycles in REPORT:
  - r_valid, r_tau and r_min stay stable; s_ready=0;
  - after the handshake, count drops by 32 and the next frame starts once 32 new samples are accepted.
- Continuous 100 Hz sine at FS=2000 over 300 samples:
  - successive frames at base 0, 32, 64...;
  - each r_tau=20; wrap-around of a 128-entry buffer is exercised.
- Assert reset mid-COMPUTE (tau=10):
  - next cycle: all outputs at reset values, busy=0, s_ready=1;
  - a refilled frame then gives correct results.
